// File: rtl/react_pkg.sv
// Shared state encoding and constants for the reaction-time trial sequencer.
package react_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LIT  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          TIME_W    = 14;
  localparam logic [TIME_W-1:0] NO_RESULT = 14'h3FFF;

endpackage

// File: rtl/react_tick.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Latency: tick is combinational from the counter, high on the wrap cycle.
// Backpressure: none, the tick is never stalled.
module react_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/react_ctrl.sv
// Reaction-time trial sequencer: random pre-light delay, ms reaction timing, best time.
// Latency: button edges act 3 clk after the pin rises; all outputs registered.
// Backpressure: none; start presses outside IDLE are dropped.
module react_ctrl
  import react_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic              react_btn,
  output logic              led,
  output logic              busy,
  output logic [TIME_W-1:0] time_ms,
  output logic              result_valid,
  output logic              false_start,
  output logic              timeout,
  output logic [TIME_W-1:0] best_ms
);

  if ((MIN_DELAY_MS + (1 << RAND_BITS) - 1 > 16383) || (TIMEOUT_MS >= 16383) ||
      (MIN_DELAY_MS < 1)) begin : g_bad_params
    $error("react_ctrl: delay or timeout parameters do not fit the 14-bit counters");
  end

  logic tick;

  react_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [1:0] start_sync;
  logic [1:0] react_sync;
  logic       start_q;
  logic       react_q;
  logic       start_edge;
  logic       react_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync <= '0;
      react_sync <= '0;
      start_q    <= 1'b0;
      react_q    <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], start_btn};
      react_sync <= {react_sync[0], react_btn};
      start_q    <= start_sync[1];
      react_q    <= react_sync[1];
    end
  end

  assign start_edge = start_sync[1] & ~start_q;
  assign react_edge = react_sync[1] & ~react_q;

  // Maximal-length polynomial x^16+x^14+x^13+x^11: a nonzero seed never reaches 0.
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  state_t            state;
  logic [TIME_W-1:0] dly;
  logic [TIME_W-1:0] rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dly          <= '0;
      rt           <= '0;
      led          <= 1'b0;
      busy         <= 1'b0;
      time_ms      <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      best_ms      <= NO_RESULT;
    end else begin
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            dly   <= TIME_W'(MIN_DELAY_MS) + TIME_W'(lfsr[RAND_BITS-1:0]);
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          // A press beats delay expiry in the same cycle: still a false start.
          if (react_edge) begin
            state       <= IDLE;
            busy        <= 1'b0;
            false_start <= 1'b1;
          end else if (tick) begin
            dly <= dly - TIME_W'(1);
            if (dly == TIME_W'(1)) begin
              state <= LIT;
              rt    <= '0;
              led   <= 1'b1;
            end
          end
        end
        LIT: begin
          if (react_edge) begin
            time_ms      <= rt;
            result_valid <= 1'b1;
            if (rt < best_ms) begin
              best_ms <= rt;
            end
            state <= IDLE;
            led   <= 1'b0;
            busy  <= 1'b0;
          end else if (tick) begin
            if (rt == TIME_W'(TIMEOUT_MS - 1)) begin
              timeout <= 1'b1;
              state   <= IDLE;
              led     <= 1'b0;
              busy    <= 1'b0;
            end else begin
              rt <= rt + TIME_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_react_ctrl.sv
// Bench for react_ctrl: directed scenarios plus randomized trials against a cycle model.
module tb_react_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int MIN_DELAY_MS = 5;
  localparam int RAND_BITS    = 2;
  localparam int TIMEOUT_MS   = 20;
  localparam int P_IDLE = 0, P_WAIT = 1, P_LIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn;
  logic        react_btn;
  logic        led, busy, result_valid, false_start, timeout;
  logic [13:0] time_ms, best_ms;

  react_ctrl #(
    .TICK_DIV(TICK_DIV), .MIN_DELAY_MS(MIN_DELAY_MS),
    .RAND_BITS(RAND_BITS), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .react_btn(react_btn),
    .led(led), .busy(busy), .time_ms(time_ms), .result_valid(result_valid),
    .false_start(false_start), .timeout(timeout), .best_ms(best_ms)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Behavioural model: trial phase, remaining delay ticks, elapsed lit ticks.
  int        m_cyc, m_phase, m_dly, m_rt;
  bit [15:0] m_lfsr;
  bit [2:0]  m_sh, m_rh;
  bit        e_led, e_busy, e_rv, e_fs, e_to;
  int        e_time, e_best;

  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    bit fb;
    fb = v[16-1] ^ v[14-1] ^ v[13-1] ^ v[11-1];
    return {v[14:0], fb};
  endfunction

  initial forever begin
    bit st_edge, re_edge, tk;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cyc = 0; m_lfsr = 16'hACE1; m_sh = '0; m_rh = '0;
      m_phase = P_IDLE; m_dly = 0; m_rt = 0;
      e_led = 0; e_busy = 0; e_rv = 0; e_fs = 0; e_to = 0;
      e_time = 0; e_best = 16383;
    end else begin
      st_edge = m_sh[1] && !m_sh[2];
      re_edge = m_rh[1] && !m_rh[2];
      tk = (m_cyc % TICK_DIV) == TICK_DIV - 1;
      e_rv = 0; e_fs = 0; e_to = 0;
      if (m_phase == P_IDLE) begin
        if (st_edge) begin
          m_dly = MIN_DELAY_MS + int'(m_lfsr) % (1 << RAND_BITS);
          m_phase = P_WAIT;
        end
      end else if (m_phase == P_WAIT) begin
        if (re_edge) begin
          m_phase = P_IDLE; e_fs = 1;
        end else if (tk) begin
          if (m_dly == 1) begin m_phase = P_LIT; m_rt = 0; end
          else m_dly--;
        end
      end else begin
        if (re_edge) begin
          e_time = m_rt; e_rv = 1;
          if (m_rt < e_best) e_best = m_rt;
          m_phase = P_IDLE;
        end else if (tk) begin
          if (m_rt == TIMEOUT_MS - 1) begin e_to = 1; m_phase = P_IDLE; end
          else m_rt++;
        end
      end
      e_led  = (m_phase == P_LIT);
      e_busy = (m_phase != P_IDLE);
      m_sh = {m_sh[1:0], start_btn};
      m_rh = {m_rh[1:0], react_btn};
      m_lfsr = lfsr_next(m_lfsr);
      m_cyc++;
    end
  end

  int n_rv = 0, n_fs = 0, n_to = 0, n_led = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("led", int'(led), int'(e_led));
      check("busy", int'(busy), int'(e_busy));
      check("result_valid", int'(result_valid), int'(e_rv));
      check("false_start", int'(false_start), int'(e_fs));
      check("timeout", int'(timeout), int'(e_to));
      check("time_ms", int'(time_ms), e_time);
      check("best_ms", int'(best_ms), e_best);
      n_rv += int'(result_valid);
      n_fs += int'(false_start);
      n_to += int'(timeout);
      n_led += int'(led);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Press start and hold it until the LED lights; lead = cycles from busy to LED.
  task automatic start_and_light(output int lead);
    int n;
    start_btn = 1'b1;
    n = 0;
    while (!busy && n < 10) begin step(); n++; end
    check("busy_rise", int'(busy), 1);
    n = 0;
    while (!led && n < 40) begin step(); n++; end
    start_btn = 1'b0;
    lead = n;
    check("led_rise", int'(led), 1);
    check_rng("delay_cycles", lead, 4 * MIN_DELAY_MS - 3, 4 * (MIN_DELAY_MS + 3));
  endtask

  task automatic run_trial(input int react_ticks);
    int lead, n;
    start_and_light(lead);
    if (react_ticks >= 0) begin
      repeat (react_ticks * TICK_DIV) step();
      react_btn = 1'b1;
      repeat (6) step();
      react_btn = 1'b0;
      repeat (2) step();
    end else begin
      n = 0;
      while (led && n < 100) begin step(); n++; end
      check("led_fall_timeout", int'(led), 0);
      repeat (2) step();
    end
  endtask

  initial begin
    int rv0, fs0, to0, led0, lead, found;
    rst = 1'b1; start_btn = 1'b0; react_btn = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_time", int'(time_ms), 0);
    check("rst_best", int'(best_ms), 14'h3FFF);

    // Timeout: LED lit for exactly 20 ticks, best untouched.
    led0 = n_led; to0 = n_to;
    run_trial(-1);
    check("to_led_cycles", n_led - led0, TIMEOUT_MS * TICK_DIV);
    check("to_pulses", n_to - to0, 1);
    check("to_best", int'(best_ms), 14'h3FFF);
    check("to_busy", int'(busy), 0);

    // Normal trial, 7 ticks.
    rv0 = n_rv;
    run_trial(7);
    check("norm_time", int'(time_ms), 7);
    check("norm_best", int'(best_ms), 7);
    check("norm_rv_pulses", n_rv - rv0, 1);
    check("norm_led", int'(led), 0);
    check("norm_busy", int'(busy), 0);

    // False start during WAIT.
    fs0 = n_fs; led0 = n_led;
    start_btn = 1'b1;
    found = 0;
    while (!busy && found < 10) begin step(); found++; end
    react_btn = 1'b1;
    found = 0;
    while (busy && found < 10) begin step(); found++; end
    start_btn = 1'b0; react_btn = 1'b0;
    repeat (3) step();
    check("fs_pulses", n_fs - fs0, 1);
    check("fs_led_cycles", n_led - led0, 0);
    check("fs_time", int'(time_ms), 7);
    check("fs_best", int'(best_ms), 7);
    check("fs_busy", int'(busy), 0);

    // Async reset while lit clears everything in the same cycle.
    start_and_light(lead);
    repeat (3) step();
    #1 rst = 1'b1;
    #1;
    check("arst_led", int'(led), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_best", int'(best_ms), 14'h3FFF);
    check("arst_time", int'(time_ms), 0);
    step();
    rst = 1'b0;
    repeat (2) step();

    // Best tracking 9, 4, 6; the third trial also gets a start press while lit.
    run_trial(9);
    check("best_a", int'(best_ms), 9);
    run_trial(4);
    check("best_b", int'(best_ms), 4);
    start_and_light(lead);
    repeat (4) step();
    start_btn = 1'b1;
    repeat (4) step();
    start_btn = 1'b0;
    check("start_ignored_led", int'(led), 1);
    check("start_ignored_busy", int'(busy), 1);
    repeat (16) step();
    react_btn = 1'b1;
    repeat (6) step();
    react_btn = 1'b0;
    repeat (2) step();
    check("best_c", int'(best_ms), 4);
    check("time_c", int'(time_ms), 6);

    // Held react: one edge only, no false start in the next trial.
    start_and_light(lead);
    repeat (2 * TICK_DIV) step();
    react_btn = 1'b1;
    repeat (6) step();
    check("held_time", int'(time_ms), 2);
    fs0 = n_fs; rv0 = n_rv;
    start_and_light(lead);
    check("held_no_fs", n_fs - fs0, 0);
    react_btn = 1'b0;
    repeat (2) step();
    react_btn = 1'b1;
    repeat (6) step();
    react_btn = 1'b0;
    repeat (2) step();
    check("held_rv_pulses", n_rv - rv0, 1);
    check("held_time2", int'(time_ms), 1);
    check("held_best", int'(best_ms), 1);

    // React edge landing on the expiry tick counts as a false start.
    fs0 = n_fs; led0 = n_led;
    start_btn = 1'b1;
    found = 0;
    while (!busy && found < 10) begin step(); found++; end
    start_btn = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (m_phase == P_WAIT && m_dly == 1 && (m_cyc + 2) % TICK_DIV == TICK_DIV - 1) found = 1;
      else step();
    end
    check("expiry_align_found", found, 1);
    react_btn = 1'b1;
    repeat (4) step();
    react_btn = 1'b0;
    repeat (2) step();
    check("expiry_fs", n_fs - fs0, 1);
    check("expiry_led_cycles", n_led - led0, 0);
    check("expiry_best", int'(best_ms), 1);

    // Randomized trials, checked every cycle by the model.
    for (int t = 0; t < 40; t++) begin
      int rdel, rh, sh;
      bit extra;
      rdel  = $urandom_range(0, 130);
      rh    = $urandom_range(1, 8);
      sh    = $urandom_range(1, 6);
      extra = 1'($urandom_range(0, 1));
      for (int c = 0; c < 250; c++) begin
        start_btn = (c < sh) || (extra && c >= 40 && c < 42);
        react_btn = (c >= rdel) && (c < rdel + rh);
        step();
        if (c > rdel + rh && c > 45 && !busy) break;
      end
      start_btn = 1'b0;
      react_btn = 1'b0;
      repeat ($urandom_range(2, 10)) step();
    end

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
